fib_run_ctrl: RTL and testbench

Synchronous run controller for the self-timed dual-rail Fibonacci ring. It holds the ring in reset between runs and releases it on a command. It then samples the ring's dual-rail output word through synchronizers and completes the output-link four-phase handshake once per term. Each decoded term is delivered on a single-clock valid/ready result port, and the run stops after a programmed term count. It sits between the clocked host logic and the asynchronous ring, and owns the ring's `rst`, `start` and `ack_i` inputs.

---
 rtl/fib_run_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fib_run_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_run_ctrl.sv
// Run controller for the self-timed dual-rail Fibonacci ring: it holds the ring in reset, releases it per command,
// and walks the four-phase output link once per term, delivering each decoded term on a valid/ready port.
module fib_run_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [15:0]          cmd_count,
  output logic                 ring_rst,
  output logic                 ring_start,
  output logic                 ring_ack,
  input  logic [2*WIDTH-1:0]   ring_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned TMO_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int unsigned TW      = $clog2(TMO_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESET,
    S_ARM,
    S_WAIT_DATA,
    S_HOLD,
    S_ACK_HI,
    S_ACK_LO,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [2*WIDTH-1:0] r_prev;
  logic [2*WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0]   w_true;
  logic [WIDTH-1:0]   w_false;
  logic               w_stable;
  logic               w_complete;
  logic               w_empty;
  logic               w_illegal;
  logic               w_accept;
  logic               w_timeout;
  logic               w_rst_done;
  logic [15:0]        r_cnt;
  logic [TW-1:0]      r_tmo;
  logic [WIDTH-1:0]   r_data;
  logic               r_last;
  logic               r_zero_done;

  // r_prev trails the last synchronizer stage so a word only counts once it is seen identical twice.
  always_ff @(posedge clk) begin
    r_sync[0] <= ring_out;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      r_sync[i] <= r_sync[i-1];
    end
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_true  = '0;
    w_false = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_true[i]  = w_sync_out[2*i+1];
      w_false[i] = w_sync_out[2*i];
    end
  end

  assign w_stable   = (w_sync_out == r_prev);
  assign w_complete = w_stable && ((w_true ^ w_false) == '1);
  assign w_empty    = w_stable && (w_sync_out == '0);
  assign w_illegal  = w_stable && (|(w_true & w_false));
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_timeout  = (r_tmo == TW'(TIMEOUT - 1));
  assign w_rst_done = (r_tmo == TW'(RST_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (w_accept) begin
          w_next = (cmd_count == '0) ? S_IDLE : S_RESET;
        end
      end
      S_RESET:     if (w_rst_done) w_next = S_ARM;
      S_ARM:       w_next = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (w_illegal)       w_next = S_ERR;
        else if (w_complete) w_next = S_HOLD;
        else if (w_timeout)  w_next = S_ERR;
      end
      S_HOLD:      if (res_ready) w_next = S_ACK_HI;
      S_ACK_HI: begin
        if (w_illegal)      w_next = S_ERR;
        else if (w_empty)   w_next = (r_cnt == 16'd1) ? S_DONE : S_ACK_LO;
        else if (w_timeout) w_next = S_ERR;
      end
      S_ACK_LO:    w_next = S_WAIT_DATA;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ring_rst   = 1'b0;
    ring_start = 1'b0;
    ring_ack   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    err        = 1'b0;
    cmd_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ring_rst  = 1'b1;
        busy      = 1'b0;
        cmd_ready = !rst;
      end
      S_RESET:     ring_rst = 1'b1;
      S_ARM,
      S_WAIT_DATA,
      S_ACK_LO:    ring_start = 1'b1;
      S_HOLD: begin
        ring_start = 1'b1;
        res_valid  = 1'b1;
      end
      S_ACK_HI: begin
        ring_start = 1'b1;
        ring_ack   = 1'b1;
      end
      S_DONE:      ring_rst = 1'b1;
      S_ERR: begin
        ring_rst  = 1'b1;
        busy      = 1'b0;
        err       = 1'b1;
        cmd_ready = !rst;
      end
      default:     ring_rst = 1'b1;
    endcase
  end

  // One cycle counter serves both the reset hold and the per-transition timeout; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_accept && (cmd_count == '0);
      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (r_tmo != '1) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_accept && (cmd_count != '0)) begin
        r_cnt <= cmd_count;
      end else if ((r_state == S_ACK_HI) && ((w_next == S_DONE) || (w_next == S_ACK_LO))) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if ((r_state == S_WAIT_DATA) && (w_next == S_HOLD)) begin
        r_data <= w_true;
        r_last <= (r_cnt == 16'd1);
      end
    end
  end

  assign done     = (r_state == S_DONE) || r_zero_done;
  assign res_data = r_data;
  assign res_last = r_last && res_valid;

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Bench for fib_run_ctrl: a behavioural dual-rail ring with skewed rail arrival, randomized delays and backpressure,
// checked against Fibonacci terms computed directly.
module tb_fib_run_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned S = 2;
  localparam int unsigned R = 4;
  localparam int unsigned T = 200;
  localparam logic [2*W-1:0] LOW_MASK  = {{W{1'b0}}, {W{1'b1}}};
  localparam logic [2*W-1:0] HIGH_MASK = {{W{1'b1}}, {W{1'b0}}};

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [15:0]    cmd_count;
  logic           ring_rst;
  logic           ring_start;
  logic           ring_ack;
  logic [2*W-1:0] ring_out;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           res_last;
  logic           busy;
  logic           done;
  logic           err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc_present = 0;
  bit silent = 1'b0;
  bit inject = 1'b0;

  fib_run_ctrl #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .RST_CYCLES(R),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .ring_rst(ring_rst),
    .ring_start(ring_start),
    .ring_ack(ring_ack),
    .ring_out(ring_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_last(res_last),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v, input bit ill);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    if (ill) begin
      r[15] = 1'b1;
      r[14] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] fib(input int k);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    a = '0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Ring model: lower half of the rails lands one cycle before the upper half, both on data and on spacer.
  initial begin : ring_model
    int ph;
    int cd;
    logic [W-1:0]   fa;
    logic [W-1:0]   fb;
    logic [W-1:0]   fn;
    logic [2*W-1:0] word;
    ring_out = '0;
    ph = 0; cd = 1; fa = '0; fb = 1; word = '0;
    forever begin
      @(negedge clk);
      if (ring_rst === 1'b1) begin
        ph = 0; fa = '0; fb = 1; ring_out = '0; cd = $urandom_range(1, 3);
      end else if (ring_start === 1'b1 && !silent) begin
        case (ph)
          0: if (ring_ack === 1'b0) begin
               if (cd > 0) cd--;
               else begin
                 word = enc(fa, inject);
                 ring_out = word & LOW_MASK;
                 ph = 1;
               end
             end
          1: begin ring_out = word; cyc_present = cyc; ph = 2; end
          2: if (ring_ack === 1'b1) begin cd = $urandom_range(0, 3); ph = 3; end
          3: if (cd > 0) cd--;
             else begin ring_out = word & HIGH_MASK; ph = 4; end
          4: begin
               ring_out = '0;
               fn = fa + fb; fa = fb; fb = fn;
               cd = $urandom_range(1, 3);
               ph = 5;
             end
          default: if (ring_ack === 1'b0) ph = 0;
        endcase
      end
    end
  end

  task automatic issue_cmd(input int n);
    int b;
    b = 0;
    while (cmd_ready !== 1'b1 && b < 100) begin @(negedge clk); b++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_count = n[15:0];
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; cmd_count = '0;
    repeat (3) @(negedge clk);
    total++;
    if (ring_rst !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        res_valid !== 1'b0 || ring_start !== 1'b0 || ring_ack !== 1'b0 || res_data !== '0 || res_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: ring_rst=%b cmd_ready=%b busy=%b done=%b err=%b res_valid=%b start=%b ack=%b data=%0h required 1,0,0,0,0,0,0,0,0",
               ring_rst, cmd_ready, busy, done, err, res_valid, ring_start, ring_ack, res_data);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
    @(negedge clk);
  endtask

  // Runs one command to completion; stall_at < 0 disables the long stall, chk_rst checks the ring reset hold.
  task automatic run_check(input int count, input bit rnd, input int stall_at, input bit chk_rst);
    int got;
    int dn;
    int budget;
    int hi;
    int stall_left;
    bit prev_v;
    bit prev_stall;
    logic [W-1:0] held;
    got = 0; dn = 0; budget = 0; hi = 0; stall_left = 50; prev_v = 0; prev_stall = 0; held = '0;
    res_ready = 1'b1;
    issue_cmd(count);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL run_start: err=%b busy=%b required 0,1", err, busy); end
    if (chk_rst) begin
      while (ring_rst === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
      total++;
      if (hi != int'(R)) begin bad++; $display("FAIL rst_hold: cycles=%0d required %0d", hi, R); end
      total++;
      if (ring_start !== 1'b1) begin bad++; $display("FAIL arm_start: ring_start=%b required 1", ring_start); end
    end
    while (dn == 0 && budget < 6000) begin
      @(negedge clk);
      budget++;
      if (res_valid === 1'b1) begin
        if (!prev_v) begin
          total++;
          if (cyc - cyc_present != int'(S) + 2) begin
            bad++; $display("FAIL valid_latency: cycles=%0d required %0d", cyc - cyc_present, S + 2);
          end
        end
        if (prev_stall) begin
          total++;
          if (res_data !== held) begin bad++; $display("FAIL hold_data: data=%0h required %0h", res_data, held); end
        end
        if (got == stall_at && stall_left > 0) begin
          stall_left--;
          res_ready = 1'b0;
          cmd_valid = 1'b1;
          cmd_count = 16'd7;
          total++;
          if (ring_ack !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b0 || res_data !== fib(got)) begin
            bad++;
            $display("FAIL stall: ack=%b err=%b cmd_ready=%b data=%0d required 0,0,0,%0d", ring_ack, err, cmd_ready, res_data, fib(got));
          end
        end else begin
          cmd_valid = 1'b0;
          res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (res_ready) begin
          total++;
          if (res_data !== fib(got) || res_last !== (got == count - 1)) begin
            bad++;
            $display("FAIL term[%0d]: data=%0d last=%b required data=%0d last=%b", got, res_data, res_last, fib(got), (got == count - 1));
          end
          got++;
        end
        prev_stall = !res_ready;
        held = res_data;
      end else begin
        res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        prev_stall = 0;
      end
      prev_v = (res_valid === 1'b1);
      if (done === 1'b1) dn++;
    end
    total++;
    if (dn == 0) begin bad++; $display("FAIL run_done: done never seen, required 1 pulse"); end
    total++;
    if (got != count) begin bad++; $display("FAIL term_count: got=%0d required %0d", got, count); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ring_rst !== 1'b1 || ring_start !== 1'b0 || ring_ack !== 1'b0) begin
      bad++;
      $display("FAIL post_run: done=%b busy=%b ring_rst=%b start=%b ack=%b required 0,0,1,0,0", done, busy, ring_rst, ring_start, ring_ack);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_basic;
    run_check(5, 1'b0, -1, 1'b1);
  endtask

  task automatic test_zero_count;
    int viol;
    viol = 0;
    issue_cmd(0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL zero_done: done=%b required 1", done); end
    repeat (20) begin
      @(negedge clk);
      if (ring_rst !== 1'b1 || res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) viol++;
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL zero_quiet: violations=%0d required 0", viol); end
  endtask

  task automatic test_backpressure;
    run_check(5, 1'b0, 2, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      run_check($urandom_range(1, 9), 1'b1, -1, 1'b1);
    end
  endtask

  task automatic test_timeout;
    int n;
    silent = 1'b1;
    issue_cmd(3);
    n = 1;
    while (err !== 1'b1 && n < int'(T) + 100) begin @(negedge clk); n++; end
    total++;
    if (n != int'(R) + int'(T) + 2) begin bad++; $display("FAIL timeout_time: cycles=%0d required %0d", n, R + T + 2); end
    total++;
    if (err !== 1'b1 || ring_rst !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || ring_start !== 1'b0) begin
      bad++;
      $display("FAIL timeout_state: err=%b ring_rst=%b busy=%b cmd_ready=%b start=%b required 1,1,0,1,0", err, ring_rst, busy, cmd_ready, ring_start);
    end
    silent = 1'b0;
    run_check(4, 1'b1, -1, 1'b1);
  endtask

  task automatic test_illegal;
    int n;
    bit saw_v;
    n = 0; saw_v = 0;
    inject = 1'b1;
    issue_cmd(3);
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) saw_v = 1;
    end
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || ring_rst !== 1'b1 || saw_v) begin
      bad++; $display("FAIL illegal_err: err=%b busy=%b ring_rst=%b saw_valid=%b required 1,0,1,0", err, busy, ring_rst, saw_v);
    end
    total++;
    if (cyc - cyc_present != int'(S) + 2) begin
      bad++; $display("FAIL illegal_latency: cycles=%0d required %0d", cyc - cyc_present, S + 2);
    end
    inject = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int n;
    n = 0;
    issue_cmd(5);
    res_ready = 1'b1;
    while (ring_ack !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    total++;
    if (ring_ack !== 1'b1) begin bad++; $display("FAIL midrun_ack: ring_ack=%b required 1", ring_ack); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ring_ack !== 1'b0 || ring_rst !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrun_abort: ack=%b ring_rst=%b res_valid=%b busy=%b cmd_ready=%b required 0,1,0,0,0",
               ring_ack, ring_rst, res_valid, busy, cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrun_ready: cmd_ready=%b required 1", cmd_ready); end
    run_check(6, 1'b1, -1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
